// File: rtl/Purple_Jade_pkg.sv
// Shared types and sizes for the rename stage.
//   NUM_ARCH_REG / NUM_PHYS_REG : architectural and physical register counts
//   decoded_instr_t             : instruction entering rename (from decode)
//   renamed_instruction_t       : instruction leaving rename (to the issue table)
package Purple_Jade_pkg;

    localparam int NUM_ARCH_REG = 8;
    localparam int NUM_PHYS_REG = 32;
    localparam int ARCH_ID_W    = $clog2(NUM_ARCH_REG);
    localparam int PHYS_ID_W    = $clog2(NUM_PHYS_REG);
    localparam int IMM_W        = 16;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_MUL    = 2'd1,
        FU_MEM    = 2'd2,
        FU_BRANCH = 2'd3
    } func_unit_e;

    typedef enum logic [2:0] {
        BCC_NONE = 3'd0,
        BCC_EQ   = 3'd1,
        BCC_NE   = 3'd2,
        BCC_LT   = 3'd3,
        BCC_GE   = 3'd4,
        BCC_LTU  = 3'd5,
        BCC_GEU  = 3'd6,
        BCC_JAL  = 3'd7
    } bcc_op_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [6:0]           opcode;
        func_unit_e           func_unit;
        logic [ARCH_ID_W-1:0] dest;
        logic [ARCH_ID_W-1:0] src1;
        logic [ARCH_ID_W-1:0] src2;
        logic                 imm;
        logic [IMM_W-1:0]     immediate;
        logic                 w_v;
        logic [3:0]           flags;
        bcc_op_e              bcc_op;
        logic                 branch_speculation;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [6:0]           opcode;
        func_unit_e           func_unit;
        logic [PHYS_ID_W-1:0] source_1;
        logic [IMM_W-1:0]     source2_imm;
        logic                 imm;
        logic                 w_v;
        logic [PHYS_ID_W-1:0] dest_id;
        logic [PHYS_ID_W-1:0] alloc_reg;
        logic [PHYS_ID_W-1:0] freed_reg;
        logic [3:0]           flags;
        bcc_op_e              bcc_op;
        logic                 branch_speculation;
    } renamed_instruction_t;

endpackage

// File: rtl/bsg_priority_encode.sv
// Priority encoder: returns the index of the first set bit of i.
//   i       : request vector
//   addr_o  : index of the winning bit ('0 when nothing is set)
//   v_o     : any bit set
// lo_to_hi_p=1 gives the lowest set index priority, otherwise the highest.
module bsg_priority_encode #(
    parameter int width_p    = 32,
    parameter bit lo_to_hi_p = 1'b1
) (
    input  logic [width_p-1:0]         i,
    output logic [$clog2(width_p)-1:0] addr_o,
    output logic                       v_o
);

    localparam int AW = $clog2(width_p);

    generate
        if (lo_to_hi_p) begin : g_lo_to_hi
            // Scan downward so the lowest set bit is the last to write.
            always_comb begin
                addr_o = '0;
                for (int k = width_p - 1; k >= 0; k--) begin
                    if (i[k]) addr_o = AW'(k);
                end
            end
        end else begin : g_hi_to_lo
            always_comb begin
                addr_o = '0;
                for (int k = 0; k < width_p; k++) begin
                    if (i[k]) addr_o = AW'(k);
                end
            end
        end
    endgenerate

    assign v_o = |i;

endmodule

// File: rtl/register_rename.sv
// Single-issue rename stage feeding the issue table.
//   clk_i, reset_i (async, active-low)
//   instruction_i/valid_i/ready_o          : decoded instruction in
//   instruction_o/valid_o/ready_i          : renamed instruction out (registered, latency 1)
//   commit_v_i/commit_arch_i/commit_alloc_i/commit_freed_i : retirement of a writing instruction
//   flush_i                                : mispredict, roll speculative state back to committed
// Keeps a speculative RAT + free bitmap (used for renaming) and a committed
// RAT + free bitmap (updated at retirement, copied back on flush).
module register_rename
    import Purple_Jade_pkg::*;
#(
    parameter int arch_regs_p = NUM_ARCH_REG,
    parameter int phys_regs_p = NUM_PHYS_REG
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  decoded_instr_t                 instruction_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output renamed_instruction_t           instruction_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    input  logic                           commit_v_i,
    input  logic [$clog2(arch_regs_p)-1:0] commit_arch_i,
    input  logic [$clog2(phys_regs_p)-1:0] commit_alloc_i,
    input  logic [$clog2(phys_regs_p)-1:0] commit_freed_i,
    input  logic                           flush_i
);

    localparam int PW = $clog2(phys_regs_p);

    // Mapping tables and free bitmaps (bit set = physical register free).
    logic [PW-1:0]          r_spec_rat [arch_regs_p];
    logic [PW-1:0]          r_comm_rat [arch_regs_p];
    logic [phys_regs_p-1:0] r_spec_free;
    logic [phys_regs_p-1:0] r_comm_free;

    logic                   r_valid;
    renamed_instruction_t   r_instr;

    logic [PW-1:0]          w_spec_rat_next [arch_regs_p];
    logic [PW-1:0]          w_comm_rat_next [arch_regs_p];
    logic [phys_regs_p-1:0] w_spec_free_next;
    logic [phys_regs_p-1:0] w_comm_free_next;
    logic [phys_regs_p-1:0] w_free_reset;

    logic [PW-1:0]          w_alloc;
    logic                   w_any_free;
    logic                   w_advance;
    logic                   w_accept;
    logic                   w_alloc_en;
    renamed_instruction_t   w_renamed;

    // Registers 0..arch_regs_p-1 hold the identity mapping out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < phys_regs_p; gi++) begin : g_free_reset
            assign w_free_reset[gi] = (gi >= arch_regs_p);
        end
    endgenerate

    // Allocation reads the registered bitmap, so a register released by a
    // commit this cycle only becomes allocatable next cycle.
    bsg_priority_encode #(
        .width_p    (phys_regs_p),
        .lo_to_hi_p (1'b1)
    ) u_free_pe (
        .i      (r_spec_free),
        .addr_o (w_alloc),
        .v_o    (w_any_free)
    );

    assign w_advance  = ~r_valid | ready_i;
    assign ready_o    = reset_i & w_advance & ~flush_i & (~instruction_i.w_v | w_any_free);
    assign w_accept   = valid_i & ready_o;
    assign w_alloc_en = w_accept & instruction_i.w_v;

    always_comb begin
        w_renamed                    = '0;
        w_renamed.pc                 = instruction_i.pc;
        w_renamed.opcode             = instruction_i.opcode;
        w_renamed.func_unit          = instruction_i.func_unit;
        w_renamed.imm                = instruction_i.imm;
        w_renamed.w_v                = instruction_i.w_v;
        w_renamed.flags              = instruction_i.flags;
        w_renamed.bcc_op             = instruction_i.bcc_op;
        w_renamed.branch_speculation = instruction_i.branch_speculation;
        w_renamed.source_1           = r_spec_rat[instruction_i.src1];
        w_renamed.source2_imm        = instruction_i.imm ? instruction_i.immediate
                                                         : IMM_W'(r_spec_rat[instruction_i.src2]);
        if (instruction_i.w_v) begin
            w_renamed.alloc_reg = w_alloc;
            w_renamed.dest_id   = w_alloc;
            w_renamed.freed_reg = r_spec_rat[instruction_i.dest];
        end
    end

    // Committed state after this cycle's retirement; also the flush target.
    always_comb begin
        w_comm_rat_next  = r_comm_rat;
        w_comm_free_next = r_comm_free;
        if (commit_v_i) begin
            w_comm_rat_next[commit_arch_i]   = commit_alloc_i;
            w_comm_free_next[commit_alloc_i] = 1'b0;
            w_comm_free_next[commit_freed_i] = 1'b1;
        end
    end

    // Allocation and release touch different bits, so both apply together.
    always_comb begin
        w_spec_rat_next  = r_spec_rat;
        w_spec_free_next = r_spec_free;
        if (flush_i) begin
            w_spec_rat_next  = w_comm_rat_next;
            w_spec_free_next = w_comm_free_next;
        end else begin
            if (w_alloc_en) begin
                w_spec_rat_next[instruction_i.dest] = w_alloc;
                w_spec_free_next[w_alloc]           = 1'b0;
            end
            if (commit_v_i) begin
                w_spec_free_next[commit_freed_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < arch_regs_p; k++) begin
                r_spec_rat[k] <= PW'(k);
                r_comm_rat[k] <= PW'(k);
            end
            r_spec_free <= w_free_reset;
            r_comm_free <= w_free_reset;
        end else begin
            r_spec_rat  <= w_spec_rat_next;
            r_comm_rat  <= w_comm_rat_next;
            r_spec_free <= w_spec_free_next;
            r_comm_free <= w_comm_free_next;
        end
    end

    // Output register holds its contents while the issue table stalls.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
            r_instr <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_accept;
            if (w_accept) r_instr <= w_renamed;
        end
    end

    assign valid_o       = r_valid;
    assign instruction_o = r_instr;

`ifndef SYNTHESIS
    // Every free-list entry is either free or held by an uncommitted writer.
    int r_inflight;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_inflight <= 0;
        end else if (flush_i) begin
            r_inflight <= 0;
        end else begin
            r_inflight <= r_inflight + (w_alloc_en ? 1 : 0) - (commit_v_i ? 1 : 0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert ($countones(r_spec_free) + r_inflight == phys_regs_p - arch_regs_p);
        end
    end
`endif

endmodule

// File: tb/tb_register_rename.sv
module tb_register_rename;
    import Purple_Jade_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 reset_i = 1'b0;
    decoded_instr_t       instruction_i;
    logic                 valid_i;
    logic                 ready_o;
    renamed_instruction_t instruction_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 commit_v_i;
    logic [2:0]           commit_arch_i;
    logic [4:0]           commit_alloc_i;
    logic [4:0]           commit_freed_i;
    logic                 flush_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    register_rename dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .instruction_i  (instruction_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .instruction_o  (instruction_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .commit_v_i     (commit_v_i),
        .commit_arch_i  (commit_arch_i),
        .commit_alloc_i (commit_alloc_i),
        .commit_freed_i (commit_freed_i),
        .flush_i        (flush_i)
    );

    // Reference model: maps, free sets and an in-order list of uncommitted writers.
    typedef struct {
        int arch;
        int alloc;
        int freed;
    } writer_t;

    int                   m_spec_map [NUM_ARCH_REG];
    int                   m_comm_map [NUM_ARCH_REG];
    bit                   m_spec_free [NUM_PHYS_REG];
    bit                   m_comm_free [NUM_PHYS_REG];
    bit                   m_valid;
    renamed_instruction_t m_out;
    writer_t              rob [$];

    task automatic model_reset();
        for (int a = 0; a < NUM_ARCH_REG; a++) begin
            m_spec_map[a] = a;
            m_comm_map[a] = a;
        end
        for (int p = 0; p < NUM_PHYS_REG; p++) begin
            m_spec_free[p] = (p >= NUM_ARCH_REG);
            m_comm_free[p] = (p >= NUM_ARCH_REG);
        end
        m_valid = 1'b0;
        m_out   = '0;
        rob.delete();
    endtask

    function automatic int lowest_free();
        for (int p = 0; p < NUM_PHYS_REG; p++) begin
            if (m_spec_free[p]) return p;
        end
        return -1;
    endfunction

    function automatic decoded_instr_t make_instr(input int d, input int s1, input int s2,
                                                  input bit wv, input bit im);
        decoded_instr_t x;
        x.pc                 = $urandom;
        x.opcode             = 7'($urandom);
        x.func_unit          = func_unit_e'(2'($urandom_range(0, 3)));
        x.dest               = 3'(d);
        x.src1               = 3'(s1);
        x.src2               = 3'(s2);
        x.imm                = im;
        x.immediate          = 16'($urandom);
        x.w_v                = wv;
        x.flags              = 4'($urandom);
        x.bcc_op             = bcc_op_e'(3'($urandom_range(0, 7)));
        x.branch_speculation = 1'($urandom);
        return x;
    endfunction

    task automatic idle_inputs();
        instruction_i  = '0;
        valid_i        = 1'b0;
        ready_i        = 1'b1;
        commit_v_i     = 1'b0;
        commit_arch_i  = '0;
        commit_alloc_i = '0;
        commit_freed_i = '0;
        flush_i        = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one cycle, returns the observed and predicted ready_o, and
    // advances the model across the clock edge. Called at posedge+1.
    task automatic do_cycle(input decoded_instr_t ins, input bit v, input bit rdy,
                            input bit cv, input int carch, input int calloc, input int cfreed,
                            input bit fl, output logic obs_ready, output bit exp_ready);
        bit                   advance;
        bit                   accept;
        int                   alloc;
        renamed_instruction_t r;
        instruction_i  = ins;
        valid_i        = v;
        ready_i        = rdy;
        commit_v_i     = cv;
        commit_arch_i  = 3'(carch);
        commit_alloc_i = 5'(calloc);
        commit_freed_i = 5'(cfreed);
        flush_i        = fl;
        #1;
        obs_ready = ready_o;

        alloc     = lowest_free();
        advance   = !m_valid || rdy;
        exp_ready = advance && !fl && (!ins.w_v || alloc >= 0);
        accept    = v && exp_ready;

        r                    = '0;
        r.pc                 = ins.pc;
        r.opcode             = ins.opcode;
        r.func_unit          = ins.func_unit;
        r.imm                = ins.imm;
        r.w_v                = ins.w_v;
        r.flags              = ins.flags;
        r.bcc_op             = ins.bcc_op;
        r.branch_speculation = ins.branch_speculation;
        r.source_1           = 5'(m_spec_map[ins.src1]);
        r.source2_imm        = ins.imm ? ins.immediate : 16'(m_spec_map[ins.src2]);
        if (ins.w_v && alloc >= 0) begin
            r.alloc_reg = 5'(alloc);
            r.dest_id   = 5'(alloc);
            r.freed_reg = 5'(m_spec_map[ins.dest]);
        end

        @(posedge clk_i);
        #1;

        if (cv) begin
            m_comm_map[carch]   = calloc;
            m_comm_free[calloc] = 1'b0;
            m_comm_free[cfreed] = 1'b1;
            m_spec_free[cfreed] = 1'b1;
            if (rob.size() > 0) void'(rob.pop_front());
        end
        if (fl) begin
            m_spec_map  = m_comm_map;
            m_spec_free = m_comm_free;
            m_valid     = 1'b0;
            rob.delete();
        end else begin
            if (accept && ins.w_v) begin
                rob.push_back('{arch: int'(ins.dest), alloc: alloc, freed: int'(r.freed_reg)});
                m_spec_map[ins.dest] = alloc;
                m_spec_free[alloc]   = 1'b0;
            end
            if (advance) begin
                m_valid = accept;
                if (accept) m_out = r;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i       = 1'b0;
        valid_i       = 1'b1;
        instruction_i = make_instr(1, 2, 3, 1'b1, 1'b0);
        @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ready_o);
        end
        checks++;
        if (instruction_o !== renamed_instruction_t'('0)) begin
            errors++;
            $display("FAIL reset_instr: got %h expected 0", instruction_o);
        end
        $display("test_reset: valid_o=%b ready_o=%b", valid_o, ready_o);
        idle_inputs();
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid: got %b expected 0", valid_o);
        end
    endtask

    task automatic test_single_add();
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        apply_reset();
        ins = make_instr(1, 2, 3, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_single_add: ready=%b valid_o=%b src1=%0d src2=%0d dest=%0d freed=%0d",
                 obs, valid_o, instruction_o.source_1, instruction_o.source2_imm,
                 instruction_o.dest_id, instruction_o.freed_reg);
        checks++;
        if (obs !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: got %b expected 1", obs);
        end
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL add_valid: got %b expected 1", valid_o);
        end
        checks++;
        if (instruction_o.source_1 !== 5'd2 || instruction_o.source2_imm !== 16'd3) begin
            errors++;
            $display("FAIL add_srcs: got %0d,%0d expected 2,3",
                     instruction_o.source_1, instruction_o.source2_imm);
        end
        checks++;
        if (instruction_o.dest_id !== 5'd8 || instruction_o.alloc_reg !== 5'd8 ||
            instruction_o.freed_reg !== 5'd1) begin
            errors++;
            $display("FAIL add_dest: got dest=%0d alloc=%0d freed=%0d expected 8,8,1",
                     instruction_o.dest_id, instruction_o.alloc_reg, instruction_o.freed_reg);
        end
        checks++;
        if (instruction_o !== m_out) begin
            errors++;
            $display("FAIL add_fields: got %h expected %h", instruction_o, m_out);
        end
    endtask

    task automatic test_chain();
        int             exp_src [3] = '{1, 8, 9};
        int             exp_dst [3] = '{8, 9, 10};
        int             exp_frd [3] = '{1, 8, 9};
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            ins = make_instr(1, 1, 1, 1'b1, 1'b0);
            do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
            $display("test_chain[%0d]: src1=%0d src2=%0d dest=%0d freed=%0d", i,
                     instruction_o.source_1, instruction_o.source2_imm,
                     instruction_o.dest_id, instruction_o.freed_reg);
            checks++;
            if (valid_o !== 1'b1 || instruction_o.source_1 !== 5'(exp_src[i]) ||
                instruction_o.source2_imm !== 16'(exp_src[i]) ||
                instruction_o.dest_id !== 5'(exp_dst[i]) ||
                instruction_o.freed_reg !== 5'(exp_frd[i])) begin
                errors++;
                $display("FAIL chain_%0d: got v=%b src=%0d/%0d dest=%0d freed=%0d expected src=%0d dest=%0d freed=%0d",
                         i, valid_o, instruction_o.source_1, instruction_o.source2_imm,
                         instruction_o.dest_id, instruction_o.freed_reg,
                         exp_src[i], exp_dst[i], exp_frd[i]);
            end
        end
    endtask

    task automatic test_exhaust();
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            ins = make_instr((i + 1) % 8, i % 8, (i + 3) % 8, 1'b1, 1'b0);
            do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
            checks++;
            if (obs !== 1'b1 || instruction_o.alloc_reg !== 5'(8 + i)) begin
                errors++;
                $display("FAIL exhaust_alloc_%0d: got ready=%b alloc=%0d expected 1,%0d",
                         i, obs, instruction_o.alloc_reg, 8 + i);
            end
        end
        ins = make_instr(5, 0, 0, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_exhaust: 25th ready=%b", obs);
        checks++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_stall: got ready=%b expected 0", obs);
        end
        do_cycle(ins, 1'b1, 1'b1, 1'b1, 1, 8, 1, 1'b0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_commit_cycle: got ready=%b expected 0", obs);
        end
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_exhaust: after commit ready=%b alloc=%0d", obs, instruction_o.alloc_reg);
        checks++;
        if (obs !== 1'b1 || valid_o !== 1'b1 || instruction_o.alloc_reg !== 5'd1) begin
            errors++;
            $display("FAIL exhaust_reuse: got ready=%b valid=%b alloc=%0d expected 1,1,1",
                     obs, valid_o, instruction_o.alloc_reg);
        end
    endtask

    task automatic test_stall();
        decoded_instr_t       a;
        decoded_instr_t       b;
        renamed_instruction_t held;
        logic                 obs;
        bit                   exp;
        apply_reset();
        a = make_instr(4, 1, 2, 1'b1, 1'b0);
        do_cycle(a, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        held = m_out;
        b = make_instr(5, 4, 4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(b, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, obs, exp);
            $display("test_stall[%0d]: ready=%b valid_o=%b out=%h", i, obs, valid_o, instruction_o);
            checks++;
            if (obs !== 1'b0 || valid_o !== 1'b1 || instruction_o !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d: got ready=%b valid=%b out=%h expected 0,1,%h",
                         i, obs, valid_o, instruction_o, held);
            end
        end
        do_cycle(b, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_stall: release src1=%0d alloc=%0d", instruction_o.source_1, instruction_o.alloc_reg);
        checks++;
        if (obs !== 1'b1 || instruction_o.source_1 !== 5'd8 || instruction_o.alloc_reg !== 5'd9 ||
            instruction_o.freed_reg !== 5'd5) begin
            errors++;
            $display("FAIL stall_release: got ready=%b src1=%0d alloc=%0d freed=%0d expected 1,8,9,5",
                     obs, instruction_o.source_1, instruction_o.alloc_reg, instruction_o.freed_reg);
        end
    endtask

    task automatic test_flush();
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        apply_reset();
        ins = make_instr(2, 0, 1, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        ins = make_instr(3, 0, 1, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        ins = make_instr(6, 2, 3, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b1, 2, 8, 2, 1'b1, obs, exp);
        $display("test_flush: flush cycle ready=%b valid_o=%b", obs, valid_o);
        checks++;
        if (obs !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got ready=%b valid=%b expected 0,0", obs, valid_o);
        end
        ins = make_instr(4, 2, 3, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_flush: after src1=%0d src2=%0d alloc=%0d", instruction_o.source_1,
                 instruction_o.source2_imm, instruction_o.alloc_reg);
        checks++;
        if (instruction_o.source_1 !== 5'd8 || instruction_o.source2_imm !== 16'd3 ||
            instruction_o.alloc_reg !== 5'd2) begin
            errors++;
            $display("FAIL flush_map: got src1=%0d src2=%0d alloc=%0d expected 8,3,2",
                     instruction_o.source_1, instruction_o.source2_imm, instruction_o.alloc_reg);
        end
        ins = make_instr(5, 0, 0, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        checks++;
        if (instruction_o.alloc_reg !== 5'd9) begin
            errors++;
            $display("FAIL flush_free9: got alloc=%0d expected 9", instruction_o.alloc_reg);
        end
    endtask

    task automatic test_random();
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        bit             v;
        bit             rdy;
        bit             cv;
        bit             fl;
        int             ca;
        int             cal;
        int             cfr;
        int             cyc_err;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ins = make_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                             1'($urandom), 1'($urandom));
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 49) == 0);
            cv  = (rob.size() > 0) && ($urandom_range(0, 2) == 0);
            ca  = 0;
            cal = 0;
            cfr = 0;
            if (cv) begin
                ca  = rob[0].arch;
                cal = rob[0].alloc;
                cfr = rob[0].freed;
            end
            cyc_err = errors;
            do_cycle(ins, v, rdy, cv, ca, cal, cfr, fl, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rand_ready_%0d: got %b expected %b", c, obs, exp);
            end
            checks++;
            if (valid_o !== m_valid) begin
                errors++;
                $display("FAIL rand_valid_%0d: got %b expected %b", c, valid_o, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (instruction_o !== m_out) begin
                    errors++;
                    $display("FAIL rand_instr_%0d: got %h expected %h", c, instruction_o, m_out);
                end
            end
            $display("test_random[%0d]: v=%b rdy=%b cv=%b fl=%b ready=%b valid_o=%b inflight=%0d %s",
                     c, v, rdy, cv, fl, obs, valid_o, rob.size(), (errors == cyc_err) ? "ok" : "bad");
        end
    endtask

    task automatic test_async_reset();
        decoded_instr_t ins;
        logic           obs;
        bit             exp;
        apply_reset();
        ins = make_instr(1, 2, 3, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        ins = make_instr(2, 1, 1, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        reset_i = 1'b0;
        #1;
        $display("test_async_reset: mid-cycle valid_o=%b ready_o=%b", valid_o, ready_o);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0 || instruction_o !== renamed_instruction_t'('0)) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b out=%h expected 0,0,0",
                     valid_o, ready_o, instruction_o);
        end
        idle_inputs();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 24; i++) begin
            ins = make_instr(1, 2, 3, 1'b1, 1'b0);
            do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
            checks++;
            if (obs !== 1'b1 || instruction_o.alloc_reg !== 5'(8 + i) ||
                instruction_o.source_1 !== 5'd2 || instruction_o.source2_imm !== 16'd3) begin
                errors++;
                $display("FAIL async_realloc_%0d: got ready=%b alloc=%0d src=%0d/%0d expected 1,%0d,2/3",
                         i, obs, instruction_o.alloc_reg, instruction_o.source_1,
                         instruction_o.source2_imm, 8 + i);
            end
        end
        ins = make_instr(3, 0, 0, 1'b1, 1'b0);
        do_cycle(ins, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, obs, exp);
        $display("test_async_reset: 25th ready=%b", obs);
        checks++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL async_full: got ready=%b expected 0", obs);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_add();
        test_chain();
        test_exhaust();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
